aqalu_seq: RTL and testbench

Parametrised, multi-cycle successor to the 2-bit AQALU. Operands are WIDTH bits and results are 2*WIDTH bits. A start/busy/done handshake covers both single-cycle and iterative ops (multiply, divide). Opcode 4'b1111 is a free-running seconds timer. The block sits between the test-vector sequencer and the result checker, and replaces the fixed-width AQALU in the verification flow.

---
 rtl/aqalu_pkg.sv | 32 +++
 rtl/aqalu_iter_muldiv.sv | 93 +++++++++
 rtl/aqalu_seq.sv | 180 ++++++++++++++++++
 tb/tb_aqalu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aqalu_pkg.sv
// Shared definitions for the sequential AQALU: opcodes, FSM states, CMP result bits.
package aqalu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1010;
  localparam logic [3:0] OP_ROL   = 4'b1011;
  localparam logic [3:0] OP_TIMER = 4'b1111;

  localparam int CMP_LT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_TIMER = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/aqalu_iter_muldiv.sv
// Shared WIDTH-step engine: unsigned shift-add multiply or restoring divide.
// The final step is combinational so the caller can register the result on the last edge.
module aqalu_iter_muldiv #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               finished
);
  import aqalu_pkg::*;

  localparam int OUT_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             active_q;
  logic             div_q;
  logic             dz_q;
  logic [CNT_W-1:0] cnt_q;
  // acc: product accumulator (MUL) or partial remainder (DIV)
  logic [OUT_W-1:0] acc_q, acc_d;
  // mcand: shifting multiplicand (MUL) or divisor in the low bits (DIV)
  logic [OUT_W-1:0] mcand_q, mcand_d;
  // z: multiplier bits consumed LSB first (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] z_q, z_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    rem_sh  = {acc_q[WIDTH-1:0], z_q[WIDTH-1]};
    trial   = {1'b0, rem_sh} - {2'b00, mcand_q[WIDTH-1:0]};
    acc_d   = acc_q;
    mcand_d = mcand_q;
    z_d     = z_q;
    if (div_q) begin
      if (trial[WIDTH+1]) begin
        acc_d = {{(WIDTH-1){1'b0}}, rem_sh};
        z_d   = {z_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {{(WIDTH-1){1'b0}}, trial[WIDTH:0]};
        z_d   = {z_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_d   = acc_q + (z_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      z_d     = z_q >> 1;
    end
  end

  assign finished = active_q && (cnt_q == CNT_LAST);

  always_comb begin
    result = acc_d;
    if (div_q) begin
      result = dz_q ? '1 : {z_d, acc_d[WIDTH-1:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      active_q <= 1'b0;
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      z_q      <= '0;
    end else if (go) begin
      active_q <= 1'b1;
      div_q    <= is_div;
      dz_q     <= (b == '0);
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, (is_div ? b : a)};
      z_q      <= is_div ? a : b;
    end else if (active_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      z_q     <= z_d;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (finished) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aqalu_seq.sv
// Multi-cycle AQALU: start/busy/done handshake, single-cycle ops, iterative MUL/DIV
// and a free-running seconds timer on opcode 1111.
module aqalu_seq #(
  parameter int WIDTH         = 4,
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         Opcode,
  input  logic               start,
  output logic [2*WIDTH-1:0] Output,
  output logic               busy,
  output logic               done
);
  import aqalu_pkg::*;

  localparam int OUT_W  = 2 * WIDTH;
  localparam int TICK_W = $clog2(TICKS_PER_SEC > 1 ? TICKS_PER_SEC : 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  state_t            state_q, state_d;
  logic              exec_q, exec_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  logic              accept;
  logic              go;
  logic [OUT_W-1:0]  alu_res;
  logic [OUT_W-1:0]  eng_result;
  logic              eng_finished;
  logic [WIDTH-1:0]  rol_a;
  logic [WIDTH-1:0]  not_a;
  logic [WIDTH:0]    shl_a;

  // An iterative op waiting to launch also blocks starts, so it cannot be overwritten
  // in the single cycle before busy rises.
  assign accept = start && !busy_q && !(exec_q && is_iter_op(op_q));

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rol
    assign rol_a[(gi + 1) % WIDTH] = a_q[gi];
  end

  assign not_a = ~a_q;
  assign shl_a = {a_q, 1'b0};

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD: alu_res = OUT_W'(a_q) + OUT_W'(b_q);
      OP_SUB: alu_res = OUT_W'(a_q) - OUT_W'(b_q);
      OP_AND: alu_res = OUT_W'(a_q) & OUT_W'(b_q);
      OP_OR:  alu_res = OUT_W'(a_q) | OUT_W'(b_q);
      OP_XOR: alu_res = OUT_W'(a_q) ^ OUT_W'(b_q);
      OP_NOT: alu_res = OUT_W'(not_a);
      OP_SHL: alu_res = OUT_W'(shl_a);
      OP_SHR: alu_res = OUT_W'(a_q) >> 1;
      OP_CMP: begin
        alu_res[CMP_LT] = (a_q < b_q);
        alu_res[CMP_EQ] = (a_q == b_q);
        alu_res[CMP_GT] = (a_q > b_q);
      end
      OP_ROL: alu_res = OUT_W'(rol_a);
      default: alu_res = '0;
    endcase
  end

  aqalu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clock   (clock),
    .reset   (reset),
    .go      (go),
    .is_div  (op_q == OP_DIV),
    .a       (a_q),
    .b       (b_q),
    .result  (eng_result),
    .finished(eng_finished)
  );

  always_comb begin
    state_d = state_q;
    exec_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tick_d  = tick_q;
    go      = 1'b0;

    case (state_q)
      ST_ITER: begin
        if (eng_finished) begin
          out_d   = eng_result;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_TIMER: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          out_d  = out_q + OUT_W'(1);
          done_d = 1'b1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: ;
    endcase

    // Latched op executes one edge after acceptance.
    if (exec_q) begin
      if (is_iter_op(op_q)) begin
        go      = 1'b1;
        busy_d  = 1'b1;
        state_d = ST_ITER;
      end else if (op_q == OP_TIMER) begin
        out_d   = '0;
        tick_d  = '0;
        done_d  = 1'b1;
        state_d = ST_TIMER;
      end else begin
        out_d   = alu_res;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    if (accept) begin
      a_d    = A;
      b_d    = B;
      op_d   = Opcode;
      exec_d = 1'b1;
      // A start inside TIMER beats a coincident second boundary.
      if (state_q == ST_TIMER) begin
        state_d = ST_IDLE;
        tick_d  = tick_q;
        out_d   = out_q;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      exec_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      exec_q  <= exec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  assign Output = out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_aqalu_seq.sv
// Directed bench for aqalu_seq at WIDTH=4, TICKS_PER_SEC=10 with hand-computed results.
module tb_aqalu_seq;

  logic       clock;
  logic       reset;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Opcode;
  logic       start;
  logic [7:0] Output;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;

  aqalu_seq #(
    .WIDTH(4),
    .TICKS_PER_SEC(10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Opcode(Opcode),
    .start (start),
    .Output(Output),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    A      = a;
    B      = b;
    Opcode = op;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic run_iter(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input bit poke, input string tag);
    int cyc;
    int busy_n;
    int leaks;
    bit seen;
    logic [7:0] prev;
    prev   = Output;
    issue(op, a, b);
    cyc    = 0;
    busy_n = 0;
    leaks  = 0;
    seen   = 1'b0;
    while (!seen && cyc < 20) begin
      if (poke && cyc == 1) begin
        A      = 4'd1;
        B      = 4'd1;
        Opcode = 4'b0000;
        start  = 1'b1;
      end
      step();
      start = 1'b0;
      cyc++;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else if (Output !== prev) leaks++;
    end
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_busy_cycles"}, busy_n, 4);
    check({tag, "_no_intermediate"}, leaks, 0);
    check({tag, "_result"}, Output, exp);
    step();
    check({tag, "_hold"}, Output, exp);
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    int dcount;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b1;
    Opcode  = 4'b0000;
    A       = 4'd5;
    B       = 4'd6;

    vecs[0]  = '{4'b0000, 4'd15, 4'd15, 8'h1E};
    vecs[1]  = '{4'b0001, 4'd3,  4'd5,  8'hFE};
    vecs[2]  = '{4'b1010, 4'd9,  4'd9,  8'h02};
    vecs[3]  = '{4'b0010, 4'hC,  4'hA,  8'h08};
    vecs[4]  = '{4'b0011, 4'hC,  4'hA,  8'h0E};
    vecs[5]  = '{4'b0100, 4'hC,  4'hA,  8'h06};
    vecs[6]  = '{4'b0101, 4'hC,  4'hA,  8'h03};
    vecs[7]  = '{4'b0110, 4'hC,  4'hA,  8'h18};
    vecs[8]  = '{4'b0111, 4'hC,  4'hA,  8'h06};
    vecs[9]  = '{4'b1011, 4'hC,  4'hA,  8'h09};
    vecs[10] = '{4'b1010, 4'd2,  4'd7,  8'h01};
    vecs[11] = '{4'b1101, 4'hF,  4'hF,  8'h00};

    // Reset held with start asserted: nothing may execute.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_out", i), Output, 0);
      check($sformatf("rst%0d_busy", i), busy, 0);
      check($sformatf("rst%0d_done", i), done, 0);
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    check("post_rst_out", Output, 0);
    check("post_rst_done", done, 0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("sc%0d_done_early", i), done, 0);
      step();
      check($sformatf("sc%0d_op%0b_result", i, vecs[i].op), Output, vecs[i].exp);
      check($sformatf("sc%0d_done", i), done, 1);
      step();
      check($sformatf("sc%0d_done_pulse", i), done, 0);
    end

    run_iter(4'b1000, 4'd13, 4'd11, 8'h8F, 1'b1, "mul_13x11");
    run_iter(4'b1001, 4'd14, 4'd3,  8'h42, 1'b0, "div_14by3");
    run_iter(4'b1001, 4'd7,  4'd0,  8'hFF, 1'b0, "div_by0");
    run_iter(4'b1000, 4'd15, 4'd15, 8'hE1, 1'b0, "mul_15x15");

    // Timer: count three seconds, then wrap.
    issue(4'b1111, 4'd0, 4'd0);
    step();
    check("tmr_start_out", Output, 0);
    check("tmr_start_done", done, 1);
    check("tmr_busy", busy, 0);
    dcount = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done) dcount++;
      if (i == 9) check("tmr_before_1s", Output, 0);
      if (i == 10) check("tmr_1s_done", done, 1);
    end
    check("tmr_3s_out", Output, 3);
    check("tmr_3s_pulses", dcount, 3);
    for (int i = 0; i < 2520; i++) step();
    check("tmr_max_out", Output, 8'hFF);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) dcount++;
    end
    check("tmr_wrap_out", Output, 8'h00);
    check("tmr_wrap_pulses", dcount, 1);
    for (int i = 0; i < 13; i++) step();
    check("tmr_mid_out", Output, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("tmr_rst_out", Output, 0);
    check("tmr_rst_done", done, 0);
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) dcount++;
    end
    check("tmr_rst_idle_out", Output, 0);
    check("tmr_rst_idle_pulses", dcount, 0);

    // Start on a second boundary wins over the increment.
    issue(4'b1111, 4'd0, 4'd0);
    step();
    for (int i = 0; i < 9; i++) step();
    check("bnd_pre_out", Output, 0);
    A      = 4'd1;
    B      = 4'd2;
    Opcode = 4'b0000;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("bnd_no_incr_out", Output, 0);
    check("bnd_no_incr_done", done, 0);
    step();
    check("bnd_add_out", Output, 3);
    check("bnd_add_done", done, 1);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) dcount++;
    end
    check("bnd_idle_out", Output, 3);
    check("bnd_idle_pulses", dcount, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
